// File: rtl/bus_mem_arbiter.sv
// bus_mem_arbiter: arbitrates the core's fetch bus (dual-word) and data bus
// (single-word load/store) onto one shared single-port memory with a
// req/ack handshake, and folds kseg0/kseg1 virtual addresses to physical.
module bus_mem_arbiter #(
  parameter int unsigned ADDR_MAP_EN = 1,
  parameter int unsigned INST_WORDS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch master
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata1,
  output logic [31:0] i_rdata2,
  output logic        i_stall,
  // data master
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Any value other than 1 is treated as a dual-word fetch.
  localparam bit TWO_WORDS = (INST_WORDS != 1);

  typedef enum logic [2:0] {
    IDLE,
    D_ACC,
    I_ACC1,
    I_ACC2,
    D_DONE,
    I_DONE
  } state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] i_rdata1_q;
  logic [31:0] i_rdata2_q;

  logic        d_req;
  logic [31:0] d_paddr;
  logic [31:0] i_paddr;

  // kseg0 (0x8..0x9) and kseg1 (0xA..0xB) both fold onto the low 512 MB.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if ((ADDR_MAP_EN != 0) && (a[31:30] == 2'b10)) begin
      return a & 32'h1FFF_FFFF;
    end
    return a;
  endfunction

  assign d_req   = d_read | d_write;
  assign d_paddr = map_addr(d_addr);
  assign i_paddr = map_addr(i_addr);

  // Arbitration FSM; all memory-side outputs and returned data are registered
  // here so a master that misbehaves mid-access cannot disturb the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      i_rdata1_q  <= '0;
      i_rdata2_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Data wins: the MEM-stage access belongs to the older instruction.
          if (d_req) begin
            state_q     <= D_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_write;
            mem_addr_q  <= d_paddr;
            mem_be_q    <= d_write ? d_be : 4'hF;
            mem_wdata_q <= d_wdata;
          end else if (i_read) begin
            state_q     <= I_ACC1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_paddr;
            mem_be_q    <= 4'hF;
            mem_wdata_q <= '0;
          end
        end
        D_ACC: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= D_DONE;
          end
        end
        I_ACC1: begin
          if (mem_ack) begin
            i_rdata1_q <= mem_rdata;
            if (TWO_WORDS) begin
              // req stays high; the second word sits 4 bytes on, wrapping at 2^32
              mem_addr_q <= mem_addr_q + 32'd4;
              state_q    <= I_ACC2;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= I_DONE;
            end
          end
        end
        I_ACC2: begin
          if (mem_ack) begin
            i_rdata2_q <= mem_rdata;
            mem_req_q  <= 1'b0;
            state_q    <= I_DONE;
          end
        end
        D_DONE:  state_q <= IDLE;
        I_DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

  assign d_rdata   = d_rdata_q;
  assign i_rdata1  = i_rdata1_q;
  assign i_rdata2  = TWO_WORDS ? i_rdata2_q : 32'h0;

  // Stalls release only in the matching DONE cycle; reset forces them low.
  assign i_stall = rst & i_read & (state_q != I_DONE);
  assign d_stall = rst & d_req & (state_q != D_DONE);

endmodule
